// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, fetch status codes and the
// PC-select state encoding.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_RET,
    ST_HALT,
    ST_ERR
  } pcs_state_e;

endpackage

// File: rtl/pc_select.sv
// Fetch-side PC generation: predicts the next PC from fetch results and
// applies jXX-mispredict and ret redirects from M and W.
module pc_select
  import y86_pkg::*;
#(
  parameter int          PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_valid,
  input  logic [3:0]       f_icode,
  input  logic [PC_W-1:0]  f_valC,
  input  logic [PC_W-1:0]  f_valP,
  input  logic             f_instr_valid,
  input  logic             f_imem_error,
  input  logic             stall_f,
  input  logic [3:0]       m_icode,
  input  logic             m_cnd,
  input  logic [PC_W-1:0]  m_valA,
  input  logic [3:0]       w_icode,
  input  logic [PC_W-1:0]  w_valM,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic [2:0]       f_stat,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  pcs_state_e       r_state;
  stat_e            r_stat;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;

  logic w_mispredict;
  logic w_ret_done;
  logic w_accept;

  assign w_mispredict = (m_icode == I_JXX) && !m_cnd;
  assign w_ret_done   = (w_icode == I_RET) && (r_state == ST_WAIT_RET);
  assign w_accept     = f_valid && !stall_f && (r_state == ST_RUN);

  // A cancelled wrong-path halt/ret/error is recovered by the M redirect,
  // so it must outrank everything; stall is the implicit hold when nothing fires.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
      r_stat  <= STAT_AOK;
      r_cnt   <= '0;
    end else if (w_mispredict) begin
      r_pc    <= m_valA;
      r_state <= ST_RUN;
      r_stat  <= STAT_AOK;
    end else if (w_ret_done) begin
      r_pc    <= w_valM;
      r_state <= ST_RUN;
    end else if (w_accept) begin
      if (f_imem_error) begin
        r_state <= ST_ERR;
        r_stat  <= STAT_ADR;
      end else if (!f_instr_valid) begin
        r_state <= ST_ERR;
        r_stat  <= STAT_INS;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        case (f_icode)
          I_HALT: begin
            r_state <= ST_HALT;
            r_stat  <= STAT_HLT;
          end
          I_RET:          r_state <= ST_WAIT_RET;
          I_JXX, I_CALL:  r_pc    <= f_valC;
          default:        r_pc    <= f_valP;
        endcase
      end
    end
  end

  assign pc        = r_pc;
  assign pc_valid  = (r_state == ST_RUN);
  assign halted    = (r_state == ST_HALT) || (r_state == ST_ERR);
  assign f_stat    = r_stat;
  assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_pc_select.sv
// Self-checking bench for pc_select: table of per-edge vectors with a
// scoreboard queue, plus hand sequences for async reset and counter wrap.
module tb_pc_select;

  localparam int PC_W  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             f_valid;
  logic [3:0]       f_icode;
  logic [PC_W-1:0]  f_valC, f_valP;
  logic             f_instr_valid, f_imem_error, stall_f;
  logic [3:0]       m_icode;
  logic             m_cnd;
  logic [PC_W-1:0]  m_valA;
  logic [3:0]       w_icode;
  logic [PC_W-1:0]  w_valM;
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic [2:0]       f_stat;
  logic             halted;
  logic [CNT_W-1:0] fetch_cnt;

  pc_select #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .f_instr_valid(f_instr_valid), .f_imem_error(f_imem_error), .stall_f(stall_f),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA),
    .w_icode(w_icode), .w_valM(w_valM),
    .pc(pc), .pc_valid(pc_valid), .f_stat(f_stat), .halted(halted),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic             fv;
    logic [3:0]       ic;
    logic [PC_W-1:0]  valc, valp;
    logic             iv, ie, st;
    logic [3:0]       mi;
    logic             mc;
    logic [PC_W-1:0]  ma;
    logic [3:0]       wi;
    logic [PC_W-1:0]  wm;
    logic [PC_W-1:0]  e_pc;
    logic             e_pv;
    logic [2:0]       e_st;
    logic             e_h;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  typedef struct {
    string            nm;
    logic [PC_W-1:0]  pc;
    logic             pv;
    logic [2:0]       st;
    logic             h;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[22];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check({e.nm, ".pc"},        pc,                e.pc);
    check({e.nm, ".pc_valid"},  64'(pc_valid),     64'(e.pv));
    check({e.nm, ".f_stat"},    64'(f_stat),       64'(e.st));
    check({e.nm, ".halted"},    64'(halted),       64'(e.h));
    check({e.nm, ".fetch_cnt"}, 64'(fetch_cnt),    64'(e.cnt));
  endtask

  // Drive one vector at the falling edge, queue its expectation, then
  // compare just after the following rising edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    f_valid = v.fv;  f_icode = v.ic;  f_valC = v.valc;  f_valP = v.valp;
    f_instr_valid = v.iv;  f_imem_error = v.ie;  stall_f = v.st;
    m_icode = v.mi;  m_cnd = v.mc;  m_valA = v.ma;
    w_icode = v.wi;  w_valM = v.wm;
    e = '{nm: v.nm, pc: v.e_pc, pv: v.e_pv, st: v.e_st, h: v.e_h, cnt: v.e_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", v.nm);
    end else begin
      check_outputs(sb.pop_front());
    end
  endtask

  task automatic idle_inputs();
    f_valid = 0; f_icode = 4'h1; f_valC = '0; f_valP = '0;
    f_instr_valid = 1; f_imem_error = 0; stall_f = 0;
    m_icode = 4'h1; m_cnd = 0; m_valA = '0;
    w_icode = 4'h1; w_valM = '0;
  endtask

  initial begin
    // fields: nm, fv, ic, valC, valP, iv, ie, stall, m_icode, m_cnd, m_valA,
    //         w_icode, w_valM | exp pc, pc_valid, f_stat, halted, fetch_cnt
    tbl[0]  = '{"opq",        1, 4'h6, 'h0,  'h2,   1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h2,   1, 3'd1, 0, 4'd1};
    tbl[1]  = '{"nop",        1, 4'h1, 'h0,  'h3,   1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h3,   1, 3'd1, 0, 4'd2};
    tbl[2]  = '{"jxx_pred",   1, 4'h7, 'h40, 'h29,  1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h40,  1, 3'd1, 0, 4'd3};
    tbl[3]  = '{"idle",       0, 4'h1, 'h0,  'h0,   1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h40,  1, 3'd1, 0, 4'd3};
    tbl[4]  = '{"mispredict", 0, 4'h1, 'h0,  'h0,   1, 0, 0, 4'h7, 0, 'h29, 4'h1, 'h0,   'h29,  1, 3'd1, 0, 4'd3};
    tbl[5]  = '{"jxx_taken",  0, 4'h1, 'h0,  'h0,   1, 0, 0, 4'h7, 1, 'h99, 4'h1, 'h0,   'h29,  1, 3'd1, 0, 4'd3};
    tbl[6]  = '{"call",       1, 4'h8, 'h80, 'h30,  1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h80,  1, 3'd1, 0, 4'd4};
    tbl[7]  = '{"ret",        1, 4'h9, 'h0,  'h81,  1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h80,  0, 3'd1, 0, 4'd5};
    tbl[8]  = '{"wait0",      1, 4'h6, 'h0,  'h55,  1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h80,  0, 3'd1, 0, 4'd5};
    tbl[9]  = '{"wait1",      1, 4'h6, 'h0,  'h55,  1, 0, 0, 4'h1, 0, 'h0,  4'h6, 'h0,   'h80,  0, 3'd1, 0, 4'd5};
    tbl[10] = '{"wait2",      1, 4'h6, 'h0,  'h55,  1, 0, 0, 4'h1, 0, 'h0,  4'hB, 'h0,   'h80,  0, 3'd1, 0, 4'd5};
    tbl[11] = '{"ret_done",   0, 4'h1, 'h0,  'h0,   1, 0, 0, 4'h1, 0, 'h0,  4'h9, 'h100, 'h100, 1, 3'd1, 0, 4'd5};
    tbl[12] = '{"ret_ignore", 0, 4'h1, 'h0,  'h0,   1, 0, 0, 4'h1, 0, 'h0,  4'h9, 'h200, 'h100, 1, 3'd1, 0, 4'd5};
    tbl[13] = '{"halt",       1, 4'h0, 'h0,  'h101, 1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h100, 0, 3'd2, 1, 4'd6};
    tbl[14] = '{"halt_ign",   1, 4'h6, 'h0,  'h77,  1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h100, 0, 3'd2, 1, 4'd6};
    tbl[15] = '{"halt_misp",  0, 4'h1, 'h0,  'h0,   1, 0, 0, 4'h7, 0, 'h20, 4'h1, 'h0,   'h20,  1, 3'd1, 0, 4'd6};
    tbl[16] = '{"stall_misp", 1, 4'h6, 'h0,  'h44,  1, 0, 1, 4'h7, 0, 'h60, 4'h1, 'h0,   'h60,  1, 3'd1, 0, 4'd6};
    tbl[17] = '{"stall",      1, 4'h6, 'h0,  'h44,  1, 0, 1, 4'h1, 0, 'h0,  4'h1, 'h0,   'h60,  1, 3'd1, 0, 4'd6};
    tbl[18] = '{"ins",        1, 4'hF, 'h0,  'h61,  0, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h60,  0, 3'd4, 1, 4'd6};
    tbl[19] = '{"ins_misp",   0, 4'h1, 'h0,  'h0,   1, 0, 0, 4'h7, 0, 'h70, 4'h1, 'h0,   'h70,  1, 3'd1, 0, 4'd6};
    tbl[20] = '{"adr",        1, 4'hF, 'h0,  'h71,  0, 1, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h70,  0, 3'd3, 1, 4'd6};
    tbl[21] = '{"err_ign",    1, 4'h6, 'h0,  'h99,  1, 0, 0, 4'h1, 0, 'h0,  4'h1, 'h0,   'h70,  0, 3'd3, 1, 4'd6};

    idle_inputs();
    rst_n = 0;
    #12;
    check_outputs('{nm: "reset", pc: '0, pv: 1, st: 3'd1, h: 0, cnt: '0});
    @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset asserted between edges while in ERR must take effect at once.
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check_outputs('{nm: "async_rst", pc: '0, pv: 1, st: 3'd1, h: 0, cnt: '0});
    idle_inputs();
    @(negedge clk);
    rst_n = 1;

    // Counter wraps modulo 2^CNT_W.
    for (int i = 0; i < 17; i++) begin
      vec_t v;
      v = '{"wrap", 1, 4'h1, 'h0, PC_W'(i + 1), 1, 0, 0, 4'h1, 0, 'h0, 4'h1, 'h0,
            PC_W'(i + 1), 1, 3'd1, 0, CNT_W'((i + 1) % 16)};
      apply(v);
    end

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
